// File: rtl/multi_bank_accfifo.sv
// multi_bank_accfifo: N-bank rotating accumulator FIFO with swap handshake and in-order drain.
// Define ACCFIFO_SAT_EN for a saturating accumulate; by default the accumulate wraps.
module multi_bank_accfifo #(
  parameter int NUM_BANKS = 2,
  parameter int DEPTH = 32,
  parameter int DATA_W = 24,
  parameter int BANK_W = $clog2(NUM_BANKS)
) (
  input logic clk,
  input logic rst,
  input logic cmp_push,
  input logic cmp_pop,
  input logic cmp_acc,
  input logic [DATA_W-1:0] cmp_din,
  output logic [DATA_W-1:0] cmp_dout,
  output logic cmp_empty,
  output logic cmp_full,
  output logic [BANK_W-1:0] cmp_bank,
  input logic swap_req,
  output logic swap_ack,
  input logic shd_pop,
  output logic [DATA_W-1:0] shd_dout,
  output logic shd_valid,
  output logic [BANK_W-1:0] shd_bank,
  output logic err_ovf,
  output logic err_udf
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
  localparam logic [BANK_W-1:0] LAST_BANK = BANK_W'(NUM_BANKS - 1);
  typedef enum logic [1:0] {FREE, COMPUTE, SEALED} bank_st_e;
  bank_st_e state_q [NUM_BANKS];
  bank_st_e state_d [NUM_BANKS];
  logic [PTR_W-1:0] rd_q [NUM_BANKS];
  logic [PTR_W-1:0] rd_d [NUM_BANKS];
  logic [PTR_W-1:0] wr_q [NUM_BANKS];
  logic [PTR_W-1:0] wr_d [NUM_BANKS];
  logic [CNT_W-1:0] cnt_q [NUM_BANKS];
  logic [CNT_W-1:0] cnt_d [NUM_BANKS];
  logic [DATA_W-1:0] mem_q [NUM_BANKS][DEPTH];
  logic [BANK_W-1:0] cmp_bank_q, cmp_bank_d, shd_bank_q, shd_bank_d, nxt_bank, shd_nxt;
  logic swap_ack_q, swap_ack_d, err_ovf_q, err_ovf_d, err_udf_q, err_udf_d;
  logic cmp_rd, cmp_wr, shd_rd, shd_free, swap_go;
  logic [DATA_W-1:0] acc_sum, wr_data;
  always_comb begin
    cmp_bank = cmp_bank_q;
    shd_bank = shd_bank_q;
    swap_ack = swap_ack_q;
    err_ovf = err_ovf_q;
    err_udf = err_udf_q;
    cmp_empty = cnt_q[cmp_bank_q] == '0;
    cmp_full = cnt_q[cmp_bank_q] == FULL_CNT;
    cmp_dout = cmp_empty ? '0 : mem_q[cmp_bank_q][rd_q[cmp_bank_q]];
    shd_valid = state_q[shd_bank_q] == SEALED && cnt_q[shd_bank_q] != '0;
    shd_free = state_q[shd_bank_q] == SEALED && cnt_q[shd_bank_q] == '0;
    shd_dout = shd_valid ? mem_q[shd_bank_q][rd_q[shd_bank_q]] : '0;
    cmp_rd = cmp_pop & ~cmp_empty;
    cmp_wr = cmp_push & (~cmp_full | cmp_rd);
    shd_rd = shd_pop & shd_valid;
    nxt_bank = cmp_bank_q == LAST_BANK ? '0 : cmp_bank_q + BANK_W'(1);
    shd_nxt = shd_bank_q == LAST_BANK ? '0 : shd_bank_q + BANK_W'(1);
    swap_go = swap_req & (state_q[nxt_bank] == FREE);
  end
`ifdef ACCFIFO_SAT_EN
  logic [DATA_W:0] sum_x;
  always_comb begin
    sum_x = {cmp_din[DATA_W-1], cmp_din} + {cmp_dout[DATA_W-1], cmp_dout};
    acc_sum = sum_x[DATA_W] ^ sum_x[DATA_W-1] ? {sum_x[DATA_W], {(DATA_W-1){~sum_x[DATA_W]}}} : sum_x[DATA_W-1:0];
  end
`else
  always_comb acc_sum = cmp_din + cmp_dout;
`endif
  always_comb wr_data = cmp_push & cmp_pop & cmp_acc ? acc_sum : cmp_din;
  always_comb begin
    state_d = state_q;
    rd_d = rd_q;
    wr_d = wr_q;
    cnt_d = cnt_q;
    cmp_bank_d = swap_go ? nxt_bank : cmp_bank_q;
    shd_bank_d = shd_free ? shd_nxt : shd_bank_q;
    swap_ack_d = swap_go;
    err_ovf_d = err_ovf_q | (cmp_push & cmp_full & ~cmp_pop);
    err_udf_d = err_udf_q | (cmp_pop & cmp_empty & ~(cmp_push & cmp_acc));
    rd_d[cmp_bank_q] = rd_q[cmp_bank_q] + PTR_W'(cmp_rd);
    wr_d[cmp_bank_q] = wr_q[cmp_bank_q] + PTR_W'(cmp_wr);
    cnt_d[cmp_bank_q] = cnt_q[cmp_bank_q] + CNT_W'(cmp_wr) - CNT_W'(cmp_rd);
    // drain bank is always SEALED, so it never aliases the compute bank here
    if (shd_rd) begin
      rd_d[shd_bank_q] = rd_q[shd_bank_q] + PTR_W'(1);
      cnt_d[shd_bank_q] = cnt_q[shd_bank_q] - CNT_W'(1);
    end
    if (shd_free) state_d[shd_bank_q] = FREE;
    if (swap_go) begin
      state_d[cmp_bank_q] = SEALED;
      state_d[nxt_bank] = COMPUTE;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_BANKS; i++) begin
        state_q[i] <= i == 0 ? COMPUTE : FREE;
        rd_q[i] <= '0;
        wr_q[i] <= '0;
        cnt_q[i] <= '0;
      end
      cmp_bank_q <= '0;
      shd_bank_q <= '0;
      swap_ack_q <= 1'b0;
      err_ovf_q <= 1'b0;
      err_udf_q <= 1'b0;
    end else begin
      state_q <= state_d;
      rd_q <= rd_d;
      wr_q <= wr_d;
      cnt_q <= cnt_d;
      cmp_bank_q <= cmp_bank_d;
      shd_bank_q <= shd_bank_d;
      swap_ack_q <= swap_ack_d;
      err_ovf_q <= err_ovf_d;
      err_udf_q <= err_udf_d;
    end
  end
  always_ff @(posedge clk) begin
    if (cmp_wr && !rst) mem_q[cmp_bank_q][wr_q[cmp_bank_q]] <= wr_data;
  end
endmodule

// File: tb/tb_multi_bank_accfifo.sv
// tb_multi_bank_accfifo: scoreboard bench for multi_bank_accfifo with 4 banks of depth 4.
module tb_multi_bank_accfifo;
  localparam int NB = 4;
  localparam int D = 4;
  localparam int W = 24;
  localparam int BW = 2;
`ifdef ACCFIFO_SAT_EN
  localparam logic [W-1:0] SAT_EXP = 24'h7FFFFF;
`else
  localparam logic [W-1:0] SAT_EXP = 24'h800000;
`endif
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic cmp_push = 1'b0, cmp_pop = 1'b0, cmp_acc = 1'b0, swap_req = 1'b0, shd_pop = 1'b0;
  logic [W-1:0] cmp_din = '0;
  logic [W-1:0] cmp_dout, shd_dout;
  logic cmp_empty, cmp_full, swap_ack, shd_valid, err_ovf, err_udf;
  logic [BW-1:0] cmp_bank, shd_bank;
  logic [W-1:0] cq[$];
  logic [W-1:0] sq[$];
  logic [W-1:0] v, e;
  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  multi_bank_accfifo #(.NUM_BANKS(NB), .DEPTH(D), .DATA_W(W), .BANK_W(BW)) dut (
    .clk(clk), .rst(rst),
    .cmp_push(cmp_push), .cmp_pop(cmp_pop), .cmp_acc(cmp_acc), .cmp_din(cmp_din),
    .cmp_dout(cmp_dout), .cmp_empty(cmp_empty), .cmp_full(cmp_full), .cmp_bank(cmp_bank),
    .swap_req(swap_req), .swap_ack(swap_ack),
    .shd_pop(shd_pop), .shd_dout(shd_dout), .shd_valid(shd_valid), .shd_bank(shd_bank),
    .err_ovf(err_ovf), .err_udf(err_udf)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input logic pu, input logic po, input logic ac, input logic [W-1:0] d,
                     input logic sw, input logic sp);
    cmp_push = pu; cmp_pop = po; cmp_acc = ac; cmp_din = d; swap_req = sw; shd_pop = sp;
    @(posedge clk);
    #1;
    cmp_push = 0; cmp_pop = 0; cmp_acc = 0; cmp_din = '0; swap_req = 0; shd_pop = 0;
  endtask

  task automatic seal();
    while (cq.size() > 0) sq.push_back(cq.pop_front());
  endtask

  function automatic logic [W-1:0] acc_ref(input logic [W-1:0] a, input logic [W-1:0] b);
    int s;
    s = int'($signed(a)) + int'($signed(b));
`ifdef ACCFIFO_SAT_EN
    if (s > 8388607) s = 8388607;
    if (s < -8388608) s = -8388608;
`endif
    return s[W-1:0];
  endfunction

  initial begin
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_banks", {cmp_bank, shd_bank}, 0);
    chk("rst_status", {cmp_empty, cmp_full, shd_valid, swap_ack, err_ovf, err_udf}, 6'b100000);
    chk("rst_cdout", cmp_dout, 0);
    chk("rst_sdout", shd_dout, 0);
    for (int i = 1; i <= 3; i++) begin
      cq.push_back(W'(i));
      cyc(1, 0, 0, W'(i), 0, 0);
      if (i == 1) chk("head_latency", {cmp_empty, cmp_dout}, 1);
    end
    chk("acc_head", cmp_dout, cq[0]);
    e = acc_ref(10, cq.pop_front());
    cq.push_back(e);
    cyc(1, 1, 1, 10, 0, 0);
    chk("acc_newhead", cmp_dout, 2);
    chk("acc_notfull", cmp_full, 0);
    cq.push_back(4);
    cyc(1, 0, 0, 4, 0, 0);
    chk("full", cmp_full, 1);
    cyc(1, 0, 0, 99, 0, 0);
    chk("ovf_flag", err_ovf, 1);
    chk("ovf_head", cmp_dout, cq[0]);
    chk("pp_head", cmp_dout, cq.pop_front());
    cq.push_back(5);
    cyc(1, 1, 0, 5, 0, 0);
    chk("pp_full", cmp_full, 1);
    while (cq.size() > 0) begin
      chk("cmp_pop_data", cmp_dout, cq.pop_front());
      cyc(0, 1, 0, 0, 0, 0);
    end
    chk("cmp_drained", cmp_empty, 1);
    chk("no_udf", err_udf, 0);
    cq.push_back(acc_ref(24'h7FFFFF, 0));
    cyc(1, 1, 1, 24'h7FFFFF, 0, 0);
    chk("eacc_head", cmp_dout, 24'h7FFFFF);
    chk("eacc_udf", err_udf, 0);
    chk("eacc_count1", {cmp_empty, cmp_full}, 0);
    v = cq.pop_front();
    cq.push_back(acc_ref(1, v));
    cyc(1, 1, 1, 1, 0, 0);
    chk("acc_overflow", cmp_dout, SAT_EXP);
    v = cq.pop_front();
    e = acc_ref(24'hFFFFFF, v);
    cq.push_back(e);
    cyc(1, 1, 1, 24'hFFFFFF, 0, 0);
    chk("acc_neg", cmp_dout, e);
    chk("acc_last", cmp_dout, cq.pop_front());
    cyc(0, 1, 0, 0, 0, 0);
    chk("acc_empty", cmp_empty, 1);
    cq.push_back(7);
    cyc(1, 0, 0, 7, 0, 0);
    cq.push_back(8);
    cyc(1, 0, 0, 8, 0, 0);
    cyc(0, 0, 0, 0, 1, 0);
    seal();
    chk("swap_ack", swap_ack, 1);
    chk("swap_bank", cmp_bank, 1);
    chk("swap_valid", shd_valid, 1);
    chk("swap_sdout", shd_dout, sq[0]);
    chk("swap_sbank", shd_bank, 0);
    cyc(0, 1, 0, 0, 0, 0);
    chk("ack_pulse", swap_ack, 0);
    chk("udf_flag", err_udf, 1);
    chk("drain_a", shd_dout, sq.pop_front());
    cyc(0, 0, 0, 0, 0, 1);
    chk("drain_valid", shd_valid, 1);
    chk("drain_b", shd_dout, sq.pop_front());
    cyc(0, 0, 0, 0, 0, 1);
    chk("drain_done", {shd_valid, shd_bank}, 0);
    cyc(0, 0, 0, 0, 0, 0);
    chk("drain_freed", shd_bank, 1);
    cyc(1, 0, 0, 5, 0, 0);
    rst = 1'b1;
    cyc(0, 0, 0, 0, 0, 0);
    rst = 1'b0;
    chk("mid_rst_banks", {cmp_bank, shd_bank}, 0);
    chk("mid_rst_status", {cmp_empty, cmp_full, shd_valid, swap_ack, err_ovf, err_udf}, 6'b100000);
    for (int i = 1; i <= 3; i++) begin
      cq.push_back(W'(i));
      cyc(1, 0, 0, W'(i), 1, 0);
      seal();
      chk("rot_ack", swap_ack, 1);
      chk("rot_bank", cmp_bank, i % NB);
    end
    chk("rot_head", {shd_valid, shd_bank, shd_dout}, {1'b1, 2'd0, 24'd1});
    cq.push_back(4);
    cyc(1, 0, 0, 4, 1, 0);
    chk("stall_ack0", swap_ack, 0);
    cyc(0, 0, 0, 0, 1, 0);
    chk("stall_ack1", swap_ack, 0);
    chk("stall_bank", cmp_bank, 3);
    chk("drain_bank0", shd_dout, sq.pop_front());
    cyc(0, 0, 0, 0, 1, 1);
    chk("post_pop_ack", swap_ack, 0);
    cyc(0, 0, 0, 0, 1, 0);
    chk("free_ack", swap_ack, 0);
    chk("free_sbank", shd_bank, 1);
    cyc(0, 0, 0, 0, 1, 0);
    seal();
    chk("late_ack", swap_ack, 1);
    chk("late_bank", cmp_bank, 0);
    for (int b = 1; b <= 3; b++) begin
      chk("seq_bank", shd_bank, b);
      chk("seq_valid", shd_valid, 1);
      chk("seq_data", shd_dout, sq.pop_front());
      cyc(0, 0, 0, 0, 0, 1);
      cyc(0, 0, 0, 0, 0, 0);
    end
    chk("seq_wrap", {shd_valid, shd_bank}, 0);
    cyc(0, 0, 0, 0, 1, 0);
    chk("eseal_ack", {swap_ack, cmp_bank, shd_bank}, {1'b1, 2'd1, 2'd0});
    chk("eseal_valid", shd_valid, 0);
    cyc(0, 0, 0, 0, 0, 0);
    chk("eseal_freed", shd_bank, 1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
